// File: rtl/protocol_frame_tx_if.sv
// Byte stream handshake between the frame transmitter and a UART transmitter.
// A byte moves on a rising clock edge where tx_valid and tx_ready are both high.
interface protocol_frame_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/protocol_frame_tx.sv
// Frame transmitter: sends an 0xFF start marker, then one encoded byte per channel.
// Define PROTOCOL_CHKSUM_EN to append a trailing XOR checksum byte.
module protocol_frame_tx #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned SW_THRESH = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_req,
    input  logic [NUM_CH*8-1:0]   ch_data,
    input  logic [NUM_CH-1:0]     ch_sig,
    protocol_frame_tx_if.master   tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam int unsigned          IDX_W    = $clog2(NUM_CH + 1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [7:0]           SOF      = 8'hFF;
    localparam logic [7:0]           SOF_SUB  = 8'hFE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_CHAN,
`ifdef PROTOCOL_CHKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [NUM_CH*8-1:0]   snap_data_q;
    logic [NUM_CH-1:0]     snap_sig_q;
    logic                  xfer_c;
    logic                  accept_c;

    logic [7:0]            tx_data_d;
    logic                  tx_valid_d;
    logic                  busy_d;
    logic                  done_d;
    logic [7:0]            ch_val;
    logic                  ch_sg;

`ifdef PROTOCOL_CHKSUM_EN
    logic [7:0]            chk_q;
    logic [7:0]            chk_d;
`endif

    assign xfer_c   = tx.tx_valid & tx.tx_ready;
    assign accept_c = (state_q == S_IDLE) & frame_req;

    // Switcher codes below the threshold; 0xFF is reserved for the start marker
    function automatic logic [7:0] encode(input logic [7:0] v, input logic s);
        logic [7:0] r;
        if (32'(v) < SW_THRESH)
            r = s ? 8'd1 : 8'd2;
        else if (v == SOF)
            r = SOF_SUB;
        else
            r = v;
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and index logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (frame_req) begin
                    state_d = S_START;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (xfer_c) state_d = S_CHAN;
            end
            S_CHAN: begin
                if (xfer_c) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
`ifdef PROTOCOL_CHKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef PROTOCOL_CHKSUM_EN
            S_CHK: begin
                if (xfer_c) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef PROTOCOL_CHKSUM_EN
    // Running XOR of the channel bytes as they are accepted
    always_comb begin
        chk_d = chk_q;
        if (accept_c)
            chk_d = '0;
        else if ((state_q == S_CHAN) && xfer_c)
            chk_d = chk_q ^ tx.tx_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) chk_q <= '0;
        else        chk_q <= chk_d;
    end
`endif

    // Output decode from the upcoming state so the registered outputs track it
    always_comb begin
        tx_data_d  = '0;
        tx_valid_d = 1'b0;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        ch_val     = '0;
        ch_sg      = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (idx_d == IDX_W'(i)) begin
                ch_val = snap_data_q[8*i +: 8];
                ch_sg  = snap_sig_q[i];
            end
        end
        case (state_d)
            S_START: begin
                tx_valid_d = 1'b1;
                tx_data_d  = SOF;
            end
            S_CHAN: begin
                tx_valid_d = 1'b1;
                tx_data_d  = encode(ch_val, ch_sg);
            end
`ifdef PROTOCOL_CHKSUM_EN
            S_CHK: begin
                tx_valid_d = 1'b1;
                tx_data_d  = (chk_d == SOF) ? SOF_SUB : chk_d;
            end
`endif
            default: begin
                tx_valid_d = 1'b0;
                tx_data_d  = '0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            tx.tx_data  <= tx_data_d;
            tx.tx_valid <= tx_valid_d;
            busy        <= busy_d;
            frame_done  <= done_d;
        end
    end

    // Snapshot taken on acceptance so later input changes cannot disturb the frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_data_q <= '0;
            snap_sig_q  <= '0;
        end else if (accept_c) begin
            snap_data_q <= ch_data;
            snap_sig_q  <= ch_sig;
        end
    end

    // Sticky drop flag; an accepted request clears it first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overrun <= 1'b0;
        else if (accept_c)
            overrun <= 1'b0;
        else if (frame_req)
            overrun <= 1'b1;
    end

endmodule

// File: tb/tb_protocol_frame_tx.sv
// Directed bench for protocol_frame_tx (NUM_CH=4, SW_THRESH=20).
// Expected byte streams adapt to PROTOCOL_CHKSUM_EN.
module tb_protocol_frame_tx;

    logic        clk;
    logic        reset;
    logic        frame_req;
    logic [31:0] ch_data;
    logic [3:0]  ch_sig;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int tests;
    int fails;
    logic [7:0] exp_q[$];

    protocol_frame_tx_if tx_if();

    protocol_frame_tx #(.NUM_CH(4), .SW_THRESH(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_req  (frame_req),
        .ch_data    (ch_data),
        .ch_sig     (ch_sig),
        .tx         (tx_if),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 32'(tx_if.tx_valid), 32'd0);
        check({tag, ".data"},  32'(tx_if.tx_data),  32'd0);
        check({tag, ".busy"},  32'(busy),           32'd0);
        check({tag, ".done"},  32'(frame_done),     32'd0);
    endtask

    // Request a frame and follow it byte by byte against exp_q
    task automatic run_frame(input string tag, input int stall_at, input int stall_len,
                             input int req_at, input int chg_at);
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s.valid%0d", tag, i), 32'(tx_if.tx_valid), 32'd1);
            check($sformatf("%s.byte%0d", tag, i),  32'(tx_if.tx_data),  32'(exp_q[i]));
            check($sformatf("%s.busy%0d", tag, i),  32'(busy),           32'd1);
            if (i == chg_at) begin
                ch_data = 32'h7777_7777;
                ch_sig  = 4'b1111;
            end
            if (i == req_at) frame_req = 1'b1;
            if (i == stall_at) begin
                tx_if.tx_ready = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    tick();
                    check($sformatf("%s.hold_valid%0d", tag, j), 32'(tx_if.tx_valid), 32'd1);
                    check($sformatf("%s.hold_byte%0d", tag, j),  32'(tx_if.tx_data),  32'(exp_q[i]));
                end
                tx_if.tx_ready = 1'b1;
            end
            tick();
            frame_req = 1'b0;
        end
        check({tag, ".done"},      32'(frame_done),      32'd1);
        check({tag, ".done_valid"}, 32'(tx_if.tx_valid), 32'd0);
        check({tag, ".done_busy"}, 32'(busy),            32'd1);
        tick();
        check_idle({tag, ".after"});
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        reset          = 1'b0;
        frame_req      = 1'b0;
        ch_data        = '0;
        ch_sig         = '0;
        tx_if.tx_ready = 1'b1;
        tick();
        tick();
        check_idle("reset");
        check("reset.overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        tick();
        check_idle("idle");

        // Basic frame: FF 01 FE 02 32 (+CF)
        ch_data = {8'd50, 8'd5, 8'hFF, 8'd5};
        ch_sig  = 4'b0001;
        exp_q   = '{8'hFF, 8'h01, 8'hFE, 8'h02, 8'h32};
`ifdef PROTOCOL_CHKSUM_EN
        exp_q.push_back(8'hCF);
`endif
        run_frame("basic", -1, 0, -1, -1);

        // Back-pressure on channel 1 for five cycles
        run_frame("stall", 2, 5, -1, -1);

        // Request dropped while busy
        run_frame("drop", -1, 0, 3, -1);
        check("drop.overrun", 32'(overrun), 32'd1);
        tick();
        check("drop.overrun_sticky", 32'(overrun), 32'd1);

        // Next accepted request clears overrun; inputs change after capture
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        check("clear.overrun", 32'(overrun), 32'd0);
        check("clear.sof", 32'(tx_if.tx_data), 32'h0000_00FF);
        for (int i = 0; i < 7; i++) tick();
        check_idle("clear.end");
        ch_data = {8'd50, 8'd5, 8'hFF, 8'd5};
        ch_sig  = 4'b0001;
        run_frame("snap", -1, 0, -1, 0);
        check("snap.ch_changed", ch_data, 32'h7777_7777);

        // Threshold boundary: 254->FE, 0/sig1->01, 19/sig0->02, 20->14
        ch_data = {8'd20, 8'd19, 8'd0, 8'd254};
        ch_sig  = 4'b0010;
        exp_q   = '{8'hFF, 8'hFE, 8'h01, 8'h02, 8'h14};
`ifdef PROTOCOL_CHKSUM_EN
        exp_q.push_back(8'hE9);
`endif
        run_frame("thresh", -1, 0, -1, -1);

        // Checksum that would equal FF goes out as FE
        ch_data = {8'd50, 8'd50, 8'd5, 8'hFF};
        ch_sig  = 4'b0010;
        exp_q   = '{8'hFF, 8'hFE, 8'h01, 8'h32, 8'h32};
`ifdef PROTOCOL_CHKSUM_EN
        exp_q.push_back(8'hFE);
`endif
        run_frame("chkff", -1, 0, -1, -1);

        // Reset mid-frame after the second byte
        ch_data = {8'd50, 8'd5, 8'hFF, 8'd5};
        ch_sig  = 4'b0001;
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        tick();
        tick();
        check("rst.pre_byte", 32'(tx_if.tx_data), 32'h0000_00FE);
        reset = 1'b0;
        #1;
        check_idle("rst.async");
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst.quiet%0d", i), 32'(tx_if.tx_valid), 32'd0);
        end
        exp_q = '{8'hFF, 8'h01, 8'hFE, 8'h02, 8'h32};
`ifdef PROTOCOL_CHKSUM_EN
        exp_q.push_back(8'hCF);
`endif
        run_frame("rst.next", -1, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/protocol_frame_tx.md
PROTOCOL_FRAME_TX -- requirements
Module: protocol_frame_tx

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of channels per frame (legal 1..16).
REQ-002 SHALL have parameter SW_THRESH, default 20, meaning that channel values below it are switcher codes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port frame_req, input, 1 bit: request to send one frame.
REQ-006 SHALL have port ch_data, input, NUM_CH*8 bits: channel n occupies bits [8n+7:8n].
REQ-007 SHALL have port ch_sig, input, NUM_CH bits: switcher state of each channel (1 = ON).
REQ-008 SHALL have port tx_ready, input, 1 bit: the UART transmitter accepts the byte when this is high.
REQ-009 SHALL have port tx_data, output, 8 bits: the byte presented to the transmitter.
REQ-010 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame is complete.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag set when a request is dropped.

Function
REQ-014 SHALL implement the states IDLE, START, CHAN, CHK and DONE, with registered outputs.
REQ-015 SHALL, on frame_req=1 in IDLE, capture ch_data and ch_sig into a snapshot register and enter START on the next edge.
- Input changes after capture SHALL NOT affect the frame.
REQ-016 SHALL, in START, drive tx_valid=1 and tx_data=8'hFF (the start-of-frame marker).
REQ-017 SHALL, in CHAN, send the channels in order 0..NUM_CH-1, encoding each one as follows:
- value < SW_THRESH: send 8'd1 if sig=1, else 8'd2.
- otherwise: send the value itself.
- value 8'hFF: send 8'hFE, so the start marker is never emitted as payload.
REQ-018 SHALL treat a byte as transferred only on a rising edge where tx_valid=1 and tx_ready=1.
- tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-019 SHALL present the next byte in the cycle after a transfer, so that back-to-back transfers sustain one byte per cycle.
REQ-020 SHALL use a channel index counter of $clog2(NUM_CH+1) bits that does not wrap.
- After the last channel is accepted, the state SHALL go to CHK if PROTOCOL_CHKSUM_EN is defined, else to DONE.
REQ-021 SHALL, in DONE, drive tx_valid=0, busy=1 and frame_done=1 for exactly one cycle, then return to IDLE.
REQ-022 SHALL drive busy=1 in every state except IDLE.
REQ-023 SHALL ignore frame_req in any state other than IDLE, and set overrun=1 when it does so.
REQ-024 SHALL clear overrun on the next request accepted in IDLE.
- If a request is accepted and a request is dropped in the same cycle, clearing SHALL take priority (the two cannot coincide in practice).
REQ-025 SHALL keep tx_valid=0 and tx_data=8'h00 in IDLE.

Reset
REQ-026 SHALL, on reset=0 and regardless of clk, set state=IDLE, tx_data=0, tx_valid=0, busy=0, frame_done=0, overrun=0, the index to 0, the checksum to 0 and the snapshot to 0.
REQ-027 SHALL, on reset asserted mid-frame, abandon the frame with no further bytes after release.
- The next frame SHALL start with 8'hFF.

Configuration
REQ-028 SHALL use the macro PROTOCOL_CHKSUM_EN to control the trailing checksum.
- Defined: CHK sends one trailing byte equal to the XOR of all encoded channel bytes (the start marker is excluded).
- If that XOR equals 8'hFF, 8'hFE SHALL be sent instead.
- Undefined: the CHK state, the checksum register and the checksum logic SHALL be absent; the frame is 1+NUM_CH bytes.

Verification
REQ-029 The bench SHALL cover this scenario: NUM_CH=4, tx_ready=1, ch_data={8'd50,8'd5,8'hFF,8'd5}, ch_sig=4'b0001, pulse frame_req -> bytes FF,01,FE,02,32 on consecutive cycles, then frame_done for 1 cycle.
REQ-030 The bench SHALL cover this scenario: same stimulus with PROTOCOL_CHKSUM_EN defined -> a sixth byte 01^FE^02^32=CF, then frame_done.
REQ-031 The bench SHALL cover this scenario: tx_ready held low 5 cycles during channel 1 -> tx_data=FE held stable with tx_valid=1, and the frame resumes with no byte lost or duplicated.
REQ-032 The bench SHALL cover this scenario: frame_req pulsed while busy=1 -> the frame is unchanged and overrun=1; the next accepted frame_req -> overrun=0.
REQ-033 The bench SHALL cover this scenario: reset=0 for one cycle after the second byte -> all outputs 0 immediately; a later frame_req produces a full frame starting FF.
REQ-034 The bench SHALL cover this scenario: ch_data changed the cycle after frame_req -> the transmitted bytes match the captured snapshot.
